avalon_bargraph_frame_master: RTL and testbench

//  Avalon-MM master that pushes a full frame into the RGB LED bargraph register slave.

---
 rtl/avalon_bargraph_frame_master.sv | 227 ++++++++++++++++++++++
 tb/tb_avalon_bargraph_frame_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bargraph_frame_master.sv
// Avalon-MM master that copies one frame from a local pixel source into the RGB bargraph slave,
// flips the display buffer and polls until the flip is seen. Optional poll timeout: BARGRAPH_FRAME_MASTER_TIMEOUT_EN.
module avalon_bargraph_frame_master #(
  parameter int            NUM_PIX    = 384,
  parameter int            AW         = 6,
  parameter logic [AW-1:0] REG_MTRX   = 6'h00,
  parameter logic [AW-1:0] REG_BUFSEL = 6'h04,
  parameter logic [AW-1:0] REG_BUFCUR = 6'h08
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
  ,
  parameter int            POLL_LIMIT = 1023
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          pix_rd,
  output logic [8:0]    pix_addr,
  input  logic [7:0]    pix_data,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  output logic          avm_write,
  output logic [3:0]    avm_byteenable,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  input  logic          avm_waitrequest,
  input  logic          avm_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_WR, S_FLIP, S_POLL_RD, S_POLL_WT, S_FIN
  } state_t;

  localparam logic [8:0] LAST_PIX = 9'(NUM_PIX - 1);

  state_t        state_r, state_nxt_s;
  logic [8:0]    cnt_r, cnt_nxt_s;
  logic          tgt_r, tgt_nxt_s;
  logic [31:0]   wdata_r, wdata_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          pix_rd_r, pix_rd_nxt_s;
  logic [8:0]    pix_addr_r, pix_addr_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic          rd_r, rd_nxt_s;
  logic          wr_r, wr_nxt_s;
  logic          unused_rdata_s;

`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
  localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);
  logic          err_r, err_nxt_s;
  logic [9:0]    poll_cnt_r, poll_nxt_s;
`endif

  assign unused_rdata_s = ^avm_readdata[31:1];

  // Next-state logic, then the bus/strobe values that the next state presents.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tgt_nxt_s   = tgt_r;
    wdata_nxt_s = wdata_r;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
    err_nxt_s   = err_r;
    poll_nxt_s  = poll_cnt_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_FETCH;
          cnt_nxt_s   = 9'd0;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
          err_nxt_s   = 1'b0;
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: state_nxt_s = S_CAPT;
      S_CAPT: begin
        // Pixel data arrives this cycle; it goes straight into the write data register.
        wdata_nxt_s = {15'b0, cnt_r, pix_data};
        state_nxt_s = S_WR;
      end
      S_WR: begin
        if (avm_waitrequest) begin
          state_nxt_s = S_WR;
        end else if (cnt_r == LAST_PIX) begin
          wdata_nxt_s = {31'b0, ~tgt_r};
          state_nxt_s = S_FLIP;
        end else begin
          cnt_nxt_s   = cnt_r + 9'd1;
          state_nxt_s = S_FETCH;
        end
      end
      S_FLIP: begin
        if (avm_waitrequest) begin
          state_nxt_s = S_FLIP;
        end else begin
          tgt_nxt_s   = ~tgt_r;
          state_nxt_s = S_POLL_RD;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
          poll_nxt_s  = 10'd0;
`endif
        end
      end
      S_POLL_RD: begin
        if (avm_waitrequest) begin
          state_nxt_s = S_POLL_RD;
        end else begin
          state_nxt_s = S_POLL_WT;
        end
      end
      S_POLL_WT: begin
        if (!avm_readdatavalid) begin
          state_nxt_s = S_POLL_WT;
        end else if (avm_readdata[0] == tgt_r) begin
          state_nxt_s = S_FIN;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
        end else if (poll_cnt_r == POLL_LAST) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = S_FIN;
        end else begin
          poll_nxt_s  = poll_cnt_r + 10'd1;
          state_nxt_s = S_POLL_RD;
        end
`else
        end else begin
          state_nxt_s = S_POLL_RD;
        end
`endif
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase

    busy_nxt_s     = 1'b1;
    done_nxt_s     = 1'b0;
    pix_rd_nxt_s   = 1'b0;
    pix_addr_nxt_s = 9'd0;
    addr_nxt_s     = {AW{1'b0}};
    rd_nxt_s       = 1'b0;
    wr_nxt_s       = 1'b0;
    case (state_nxt_s)
      S_IDLE: busy_nxt_s = 1'b0;
      S_FETCH: begin
        pix_rd_nxt_s   = 1'b1;
        pix_addr_nxt_s = cnt_nxt_s;
      end
      S_CAPT: busy_nxt_s = 1'b1;
      S_WR: begin
        wr_nxt_s   = 1'b1;
        addr_nxt_s = REG_MTRX;
      end
      S_FLIP: begin
        wr_nxt_s   = 1'b1;
        addr_nxt_s = REG_BUFSEL;
      end
      S_POLL_RD: begin
        rd_nxt_s   = 1'b1;
        addr_nxt_s = REG_BUFCUR;
      end
      S_POLL_WT: busy_nxt_s = 1'b1;
      S_FIN: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // State, counters and registered outputs; reset drops the bus strobes immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 9'd0;
      tgt_r      <= 1'b0;
      wdata_r    <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pix_rd_r   <= 1'b0;
      pix_addr_r <= 9'd0;
      addr_r     <= {AW{1'b0}};
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
      err_r      <= 1'b0;
      poll_cnt_r <= 10'd0;
`endif
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      tgt_r      <= tgt_nxt_s;
      wdata_r    <= wdata_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      pix_rd_r   <= pix_rd_nxt_s;
      pix_addr_r <= pix_addr_nxt_s;
      addr_r     <= addr_nxt_s;
      rd_r       <= rd_nxt_s;
      wr_r       <= wr_nxt_s;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
      err_r      <= err_nxt_s;
      poll_cnt_r <= poll_nxt_s;
`endif
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign pix_rd         = pix_rd_r;
  assign pix_addr       = pix_addr_r;
  assign avm_address    = addr_r;
  assign avm_read       = rd_r;
  assign avm_write      = wr_r;
  assign avm_writedata  = wdata_r;
  assign avm_byteenable = 4'hF;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
  assign err            = err_r;
`else
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_bargraph_frame_master.sv
// Scoreboard bench for avalon_bargraph_frame_master: random bus slave, random pixel frames,
// expected writes queued at start and checked by an independent monitor.
`timescale 1ns/1ps
module tb_avalon_bargraph_frame_master;
  localparam int NUM_PIX = 4;
  localparam int AW      = 6;
  localparam logic [5:0] A_MTRX   = 6'h00;
  localparam logic [5:0] A_BUFSEL = 6'h04;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
  localparam int POLL_LIMIT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err, pix_rd, avm_read, avm_write;
  logic [8:0]  pix_addr;
  logic [7:0]  pix_data = 8'h00;
  logic [5:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;

  always #5 clock = ~clock;

  avalon_bargraph_frame_master #(
    .NUM_PIX(NUM_PIX), .AW(AW)
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
    , .POLL_LIMIT(POLL_LIMIT)
`endif
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid)
  );

  typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;
  wr_t  exp_wr_q[$];
  logic [7:0] mem [NUM_PIX];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mism_plan = 0;
  logic force5 = 1'b0;
  logic hold_wait = 1'b0;
  logic real_rdv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expected_reads(input int m);
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
    return (m + 1 < POLL_LIMIT) ? m + 1 : POLL_LIMIT;
`else
    return m + 1;
`endif
  endfunction

  // Bus slave and pixel source: responds on the falling edge.
  initial begin : slave
    int   stall_left;
    int   lat;
    int   mism_left;
    logic in_xfer, fetch_prev, sel_val, rd_val;
    logic [1:0] fetch_addr;
    stall_left = 0; lat = 0; mism_left = 0; in_xfer = 1'b0; fetch_prev = 1'b0;
    sel_val = 1'b0; rd_val = 1'b0; fetch_addr = 2'd0;
    forever begin
      @(negedge clock);
      real_rdv          = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (reset) begin
        stall_left = 0; lat = 0; in_xfer = 1'b0; fetch_prev = 1'b0;
        avm_waitrequest = 1'b0;
        pix_data = 8'($urandom);
      end else begin
        pix_data   = fetch_prev ? mem[fetch_addr] : 8'($urandom);
        fetch_prev = pix_rd;
        fetch_addr = pix_addr[1:0];
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            avm_readdatavalid = 1'b1;
            real_rdv          = 1'b1;
            avm_readdata      = {$urandom_range(0, 32'h7FFF_FFFF), rd_val};
          end
        end else if (avm_write && $urandom_range(0, 3) == 0) begin
          avm_readdatavalid = 1'b1;
        end
        if (avm_write || avm_read) begin
          if (!in_xfer) begin
            in_xfer = 1'b1;
            if (hold_wait) stall_left = 1000000;
            else if (force5 && avm_write && avm_address == A_MTRX && avm_writedata[16:8] == 9'd2)
              stall_left = 5;
            else stall_left = $urandom_range(0, 2);
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
            in_xfer = 1'b0;
            if (avm_read) begin
              lat    = $urandom_range(1, 3);
              rd_val = (mism_left > 0) ? ~sel_val : sel_val;
              if (mism_left > 0) mism_left--;
            end else if (avm_address == A_BUFSEL) begin
              sel_val   = avm_writedata[0];
              mism_left = mism_plan;
            end
          end
        end else begin
          avm_waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: checks bus rules, pops expected writes, tracks the frame-level model.
  initial begin : monitor
    int   phase;
    int   reads;
    logic err_m, poll_tgt, prev_stall, p_wr, p_rd;
    logic [5:0]  p_addr;
    logic [31:0] p_data;
    wr_t  e;
    phase = 0; reads = 0; err_m = 1'b0; poll_tgt = 1'b0; prev_stall = 1'b0;
    p_wr = 1'b0; p_rd = 1'b0; p_addr = 6'd0; p_data = 32'd0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        phase = 0; reads = 0; err_m = 1'b0; prev_stall = 1'b0;
      end else begin
        check("busy", 32'(busy), 32'(phase == 1));
        check("done", 32'(done), 32'(phase == 2));
        check("err", 32'(err), 32'(err_m));
        check("rd_wr_excl", 32'(avm_read & avm_write), 32'd0);
        check("byteenable", 32'(avm_byteenable), 32'hF);
        if (prev_stall) begin
          check("stall_addr", 32'(avm_address), 32'(p_addr));
          check("stall_data", avm_writedata, p_data);
          check("stall_wr", 32'(avm_write), 32'(p_wr));
          check("stall_rd", 32'(avm_read), 32'(p_rd));
        end
        prev_stall = (avm_write | avm_read) & avm_waitrequest;
        p_addr = avm_address; p_data = avm_writedata; p_wr = avm_write; p_rd = avm_read;
        if (avm_write && !avm_waitrequest) begin
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write", avm_writedata, 32'hDEAD_BEEF);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", 32'(avm_address), 32'(e.addr));
            check("wr_data", avm_writedata, e.data);
            if (e.addr == A_BUFSEL) poll_tgt = e.data[0];
          end
        end
        case (phase)
          0: if (start) begin
            phase = 1; err_m = 1'b0; reads = 0;
          end
          1: if (real_rdv) begin
            reads++;
            if (avm_readdata[0] == poll_tgt) phase = 2;
`ifdef BARGRAPH_FRAME_MASTER_TIMEOUT_EN
            else if (reads == POLL_LIMIT) begin
              phase = 2; err_m = 1'b1;
            end
`endif
          end
          2: begin
            check("frame_reads", 32'(reads), 32'(expected_reads(mism_plan)));
            check("writes_left", 32'(exp_wr_q.size()), 32'd0);
            phase = 0;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  logic sel_m = 1'b0;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run_frame(input int f, input int mism, input bit start_on_done);
    int budget;
    int spur;
    for (int i = 0; i < NUM_PIX; i++) begin
      mem[i] = (f == 0) ? 8'(i) + 8'h10 : 8'($urandom);
      exp_wr_q.push_back('{addr: A_MTRX, data: {15'b0, 9'(i), mem[i]}});
    end
    sel_m = ~sel_m;
    exp_wr_q.push_back('{addr: A_BUFSEL, data: {31'b0, sel_m}});
    mism_plan = mism;
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 0;
    spur = $urandom_range(2, 12);
    while (!done && budget < 500) begin
      start = (budget == spur);
      tick();
      budget++;
    end
    start = 1'b0;
    if (!done) begin
      check("frame_timeout", 32'(done), 32'd1);
    end else if (start_on_done) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    repeat ($urandom_range(1, 4)) tick();
  endtask

  initial begin : driver
    int budget;
    for (int i = 0; i < NUM_PIX; i++) mem[i] = 8'h00;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pix_rd", 32'(pix_rd), 32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_address", 32'(avm_address), 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_byteenable", 32'(avm_byteenable), 32'hF);
    reset = 1'b0;
    tick();

    force5 = 1'b1;
    run_frame(0, 3, 1'b0);
    force5 = 1'b0;
    run_frame(1, 0, 1'b1);
    run_frame(2, 8, 1'b0);
    for (int f = 3; f < 12; f++) run_frame(f, $urandom_range(0, 5), 1'($urandom_range(0, 1)));

    // Reset while a pixel write is stalled, then a clean frame must start at pixel 0.
    hold_wait = 1'b1;
    for (int i = 0; i < NUM_PIX; i++) mem[i] = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 0;
    while (!avm_write && budget < 50) begin
      tick();
      budget++;
    end
    check("hold_write_seen", 32'(avm_write), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("async_write_drop", 32'(avm_write), 32'd0);
    check("async_busy_drop", 32'(busy), 32'd0);
    exp_wr_q.delete();
    hold_wait = 1'b0;
    sel_m = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    run_frame(20, 1, 1'b0);
    run_frame(21, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
